// File: rtl/serial_word_receiver_pkg.sv
// serial_word_receiver_pkg
// Shared types and constants for the serial word receiver.
//   rx_state_t : receiver state (IDLE waiting for a frame start, SHIFT mid-word)
//   ORDER_LSB  : bit-order code meaning the first received bit is bit 0
//   ORDER_MSB  : bit-order code meaning the first received bit is bit WIDTH-1
package serial_word_receiver_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_t;

   localparam logic ORDER_LSB = 1'b1;
   localparam logic ORDER_MSB = 1'b0;

endpackage

// File: rtl/rx_out_slot.sv
// rx_out_slot
// Single-entry valid/ready holding register for completed words.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load          : capture din this cycle (caller guarantees slot is free or draining)
//   din           : word to capture
//   m_data        : held word, stable while m_valid is high, keeps last value after drain
//   m_valid       : word available
//   m_ready       : consumer takes the word when m_valid & m_ready
//   full          : slot currently holds an undelivered word
module rx_out_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             full
);

   // A load wins over a drain, so a word arriving in the same cycle the
   // consumer takes the old one keeps m_valid high without a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_data  <= '0;
         m_valid <= 1'b0;
      end else if (load) begin
         m_data  <= din;
         m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
      end
   end

   assign full = m_valid;

endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver
// Assembles framed single-bit streams into WIDTH-bit words, LSB-first or
// MSB-first, and hands them to a one-entry valid/ready output slot.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   lsb_first  : bit order, sampled together with the framing bit
//   s_din      : serial data bit
//   s_valid    : bit strobe
//   s_frame    : current bit is the first bit of a word (only with s_valid)
//   m_data     : received word
//   m_valid    : word available
//   m_ready    : consumer accepts the word
//   busy       : a word is partially received
//   overrun    : one-cycle pulse, a completed word was dropped (slot full)
//   frame_err  : one-cycle pulse, a new frame started mid-word
module serial_word_receiver
   import serial_word_receiver_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lsb_first,
   input  logic             s_din,
   input  logic             s_valid,
   input  logic             s_frame,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   rx_state_t        state;
   logic [CW-1:0]    cnt;
   logic             order_q;
   logic [WIDTH-1:0] sr;
   logic             done_q;

   logic             first_bit;
   logic             last_bit;
   logic             accept;
   logic             bit_order;
   logic [WIDTH-1:0] shifted;
   logic             slot_full;
   logic             slot_load;

   // A framing bit always starts a fresh word, from either state. The first
   // bit of a word must use the order sampled alongside it, not the stale
   // order_q left over from the previous frame.
   always_comb begin
      first_bit = s_valid & s_frame;
      accept    = s_valid & (s_frame | (state == SHIFT));
      last_bit  = s_valid & ~s_frame & (state == SHIFT) & (cnt == LAST_CNT);
      bit_order = first_bit ? lsb_first : order_q;
      if (bit_order == ORDER_LSB) begin
         shifted = {s_din, sr[WIDTH-1:1]};
      end else begin
         shifted = {sr[WIDTH-2:0], s_din};
      end
   end

   // Receive FSM. When the final bit is accepted, sr holds the finished word
   // and done_q flags it for one cycle; the output slot picks it up on the
   // next edge. sr is not overwritten before then, because the earliest
   // following bit lands on that same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         order_q   <= ORDER_LSB;
         sr        <= '0;
         done_q    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         frame_err <= 1'b0;
         if (accept) begin
            sr <= shifted;
            if (first_bit) begin
               order_q   <= lsb_first;
               cnt       <= CW'(1);
               state     <= SHIFT;
               frame_err <= (state == SHIFT);
            end else if (last_bit) begin
               cnt    <= '0;
               state  <= IDLE;
               done_q <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   // The finished word may enter the slot when the slot is empty or is being
   // drained in the same cycle. Otherwise the word is lost and overrun is flagged.
   always_comb begin
      slot_load = done_q & (~slot_full | m_ready);
   end

   // Overrun is registered so it lines up with the other status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun <= 1'b0;
      end else begin
         overrun <= done_q & slot_full & ~m_ready;
      end
   end

   assign busy = (state == SHIFT);

   rx_out_slot #(
      .WIDTH (WIDTH)
   ) u_out_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (slot_load),
      .din     (sr),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .full    (slot_full)
   );

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-to-parallel receiver that assembles framed single-bit streams into WIDTH-bit words and presents them on a valid/ready parallel port. Pairs with the universal shift register used as a serializer: accepts either LSB-first (right-shift) or MSB-first (left-shift) bit order. Double-buffered (shift stage plus output slot) so reception continues while a completed word awaits its consumer.

## Interface
- WIDTH, 8, word width in bits; legal range WIDTH >= 2
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- lsb_first  input  1  bit order for the word; sampled only with the framing bit (1 = first bit is bit 0)
- s_din  input  1  serial data bit
- s_valid  input  1  s_din valid this cycle (bit strobe)
- s_frame  input  1  marks current bit as the first bit of a word; ignored unless s_valid = 1
- m_data  output  WIDTH  received word; stable while m_valid = 1
- m_valid  output  1  word available
- m_ready  input  1  consumer accepts word when m_valid & m_ready
- busy  output  1  1 while a word is partially received (state SHIFT)
- overrun  output  1  one-cycle pulse: completed word dropped, output slot full
- frame_err  output  1  one-cycle pulse: s_frame arrived mid-word

## Operation
- States: IDLE, SHIFT. Bit counter cnt, range 0..WIDTH-1, width $clog2(WIDTH).
- IDLE: s_valid & s_frame -> accept bit, latch lsb_first into order_q, cnt <= 1, go SHIFT. s_valid without s_frame -> bit discarded, no flag.
- SHIFT, s_valid & !s_frame: accept bit, cnt <= cnt+1.
- Shift rule: order_q = 1 -> sr <= {s_din, sr[WIDTH-1:1]}; order_q = 0 -> sr <= {sr[WIDTH-2:0], s_din}. First bit of a frame uses the lsb_first sampled in the same cycle.
- Completion: bit accepted with cnt = WIDTH-1 -> assembled word (sr with that bit shifted in) offered to output slot, state -> IDLE, cnt <= 0.
- Output slot: loads on completion if empty or being drained the same cycle (m_valid & m_ready). Otherwise word discarded, overrun pulses, m_data/m_valid unchanged.
- SHIFT, s_valid & s_frame: frame_err pulses, partial word discarded, bit treated as first bit of a new word (order re-sampled, cnt <= 1, remain SHIFT).
- s_valid = 0: no state change in either state; gaps between bits of any length allowed.
- m_valid & m_ready with no completion: m_valid <= 0; m_data holds last value.

## Timing
- Reset (rst = 1 at a clock edge): state IDLE, cnt 0, sr 0, m_data 0, m_valid 0, busy 0, overrun 0, frame_err 0. Reset mid-word discards the partial word and any pending output word.
- Latency: m_valid rises on the clock edge after the edge that accepts bit WIDTH-1.
- Back-to-back: next frame may start the cycle after completion; throughput one bit per cycle sustained.
- Simultaneous drain and completion: new word loaded, m_valid stays 1, no overrun.
- overrun and frame_err are registered, asserted for exactly the cycle after the triggering edge.
- busy = (state == SHIFT), registered.

## Structure
- Package serial_word_receiver_pkg: state typedef (IDLE, SHIFT), order encoding constants (ORDER_LSB = 1, ORDER_MSB = 0).
- One sub-module: rx_out_slot, single-entry valid/ready holding register (load, data in, m_data/m_valid/m_ready, full flag); overrun decision stays in the top level.

## Test plan
- WIDTH=8, lsb_first=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, m_ready=1 -> m_data=0x4D, m_valid one cycle, edge after last bit.
- Same bits, lsb_first=0 -> m_data=0xB2; toggle lsb_first mid-word -> no effect on result.
- m_ready=0, two full words sent back to back (0x4D then 0xB2) -> m_data stays 0x4D, overrun pulses once; raise m_ready the cycle the second word completes -> 0xB2 loaded, no overrun.
- 3 bits sent, then s_frame with new 8-bit word 0xFF -> frame_err one pulse, m_data=0xFF, no partial word emitted.
- rst asserted after 5 bits, then full word 0x01 (lsb_first=1) -> all outputs 0 during reset, next m_data=0x01; s_valid bits without s_frame in IDLE -> no m_valid.
